// File: rtl/uart_alu_interface.sv
// Bridges received UART frames to the ALU operand/operator registers and hands
// each ALU result to the UART transmitter with a start/done handshake.
module uart_alu_interface #(
    parameter int unsigned NB_DATA   = 8,
    parameter int unsigned NB_OP     = 6,
    parameter int unsigned NB_OPCODE = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_rx_done,
    input  logic [NB_OPCODE+NB_DATA-1:0]  i_data,
    input  logic [NB_DATA-1:0]            i_alu_result,
    input  logic                          i_tx_done,
    output logic [NB_DATA-1:0]            o_data_a,
    output logic [NB_DATA-1:0]            o_data_b,
    output logic [NB_OP-1:0]              o_op,
    output logic [NB_DATA-1:0]            o_tx_data,
    output logic                          o_tx_start,
    output logic                          o_busy,
    output logic                          o_overrun
);

    localparam logic [NB_OPCODE-1:0] OPC_A  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OPC_B  = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OPC_OP = NB_OPCODE'(3);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_TX_WAIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NB_DATA-1:0]     r_data_a;
    logic [NB_DATA-1:0]     r_data_b;
    logic [NB_OP-1:0]       r_op;
    logic [NB_DATA-1:0]     r_tx_data;
    logic                   r_tx_start;
    logic                   r_busy;
    logic                   r_overrun;

    logic [NB_DATA-1:0]     w_data_a_next;
    logic [NB_DATA-1:0]     w_data_b_next;
    logic [NB_OP-1:0]       w_op_next;
    logic [NB_DATA-1:0]     w_tx_data_next;
    logic                   w_tx_start_next;
    logic                   w_busy_next;
    logic                   w_overrun_next;

    logic [NB_OPCODE-1:0]   w_opcode;
    logic [NB_DATA-1:0]     w_payload;
    logic                   w_op_frame;

    assign w_opcode   = i_data[NB_OPCODE+NB_DATA-1 -: NB_OPCODE];
    assign w_payload  = i_data[NB_DATA-1:0];
    assign w_op_frame = i_rx_done && (w_opcode == OPC_OP);

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_op       <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_data_a   <= w_data_a_next;
            r_data_b   <= w_data_b_next;
            r_op       <= w_op_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_busy     <= w_busy_next;
            r_overrun  <= w_overrun_next;
        end
    end

    // Frame decode, next state and next output values
    always_comb begin
        w_state_next    = r_state;
        w_data_a_next   = r_data_a;
        w_data_b_next   = r_data_b;
        w_op_next       = r_op;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_overrun_next  = 1'b0;

        // Operands may be reloaded in any state; the byte in flight is already latched.
        if (i_rx_done && (w_opcode == OPC_A)) begin
            w_data_a_next = w_payload;
        end
        if (i_rx_done && (w_opcode == OPC_B)) begin
            w_data_b_next = w_payload;
        end

        case (r_state)
            S_IDLE: begin
                if (w_op_frame) begin
                    w_op_next    = w_payload[NB_OP-1:0];
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_overrun_next  = w_op_frame;
                w_tx_data_next  = i_alu_result;
                w_tx_start_next = 1'b1;
                w_state_next    = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                w_overrun_next = w_op_frame;
                if (i_tx_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    assign o_data_a   = r_data_a;
    assign o_data_b   = r_data_b;
    assign o_op       = r_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Consumes the 10-bit frames produced by the UART receiver path (baud rate generator + rx) on each rx_done pulse.
- Decodes the 2-bit opcode, loads operand A, operand B or the operator, and drives them to the ALU.
- On an operator frame it captures the ALU result and hands it to the UART transmitter with a start/done handshake.
- Sits between the rx side of top_uart and the ALU/tx side of the top level.

Parameters:
- NB_DATA, 8, payload/operand width
- NB_OP, 6, ALU operator code width (low bits of the operator payload)
- NB_OPCODE, 2, frame opcode width

Ports:
- i_clk  in  1  system clock (50 MHz)
- i_reset  in  1  synchronous, active-high reset
- i_rx_done  in  1  one-cycle pulse: i_data holds a new received frame
- i_data  in  NB_OPCODE+NB_DATA  frame: [9:8] opcode, [7:0] payload
- i_alu_result  in  NB_DATA  combinational ALU result for o_data_a/o_data_b/o_op
- i_tx_done  in  1  pulse from transmitter: byte fully sent
- o_data_a  out  NB_DATA  operand A to ALU
- o_data_b  out  NB_DATA  operand B to ALU
- o_op  out  NB_OP  operator code to ALU
- o_tx_data  out  NB_DATA  byte for transmitter
- o_tx_start  out  1  one-cycle pulse: start transmission of o_tx_data
- o_busy  out  1  high while state != S_IDLE
- o_overrun  out  1  one-cycle pulse: operator frame dropped

Behaviour:
- All outputs registered. Reset (i_reset high at a rising edge) clears every output to 0, state to S_IDLE. Reset mid-operation aborts immediately; no o_tx_start pulse follows.
- Opcode decode on the cycle i_rx_done=1; i_data is ignored when i_rx_done=0:
  - 00: reserved; ignored, no output change.
  - 01: o_data_a <= payload, at the next edge, in any state.
  - 10: o_data_b <= payload, at the next edge, in any state.
  - 11: o_op <= payload[NB_OP-1:0]. Accepted only in S_IDLE; any other state drops it (o_op unchanged) and pulses o_overrun for 1 cycle.
- Operand updates during S_EXEC/S_TX_WAIT are allowed. The byte in flight is already latched in o_tx_data and is unaffected.
- FSM states: S_IDLE, S_EXEC, S_TX_WAIT.
  - S_IDLE -> S_EXEC: accepted opcode-11 frame.
  - S_EXEC: one cycle for the ALU to settle. At its closing edge: o_tx_data <= i_alu_result, o_tx_start <= 1, -> S_TX_WAIT.
  - S_TX_WAIT: o_tx_start forced back to 0 after one cycle; o_tx_data held stable. i_tx_done=1 -> S_IDLE. No timeout; waits indefinitely.
- Latency: opcode-11 i_rx_done in cycle N -> o_op valid from N+1 -> o_tx_start high exactly in cycle N+2 with the result of (A,B,op) as held in N+1.
- An i_tx_done pulse outside S_TX_WAIT is ignored.
- Zero operands: an operator frame with A/B never loaded since reset computes on the reset value 0.
- Simultaneous i_rx_done (opcode 11) and i_tx_done in S_TX_WAIT: frame dropped with o_overrun; state returns to S_IDLE.
- Width rules: payload bits [7:NB_OP] of an operator frame are discarded; no sign or width conversion of operands.

Test Plan:
- Reset: assert i_reset 2 cycles with random inputs -> all outputs 0, o_busy 0.
- Basic op: frames 01_0x55, 10_0x0F, 11_0x20 (ADD), behavioural ALU, tx model replies i_tx_done 10 cycles after start -> o_data_a=0x55, o_data_b=0x0F, o_op=0x20; o_tx_start single pulse exactly 2 cycles after the op rx_done; o_tx_data=0x64; o_busy falls the cycle after i_tx_done.
- Operand update while busy: during S_TX_WAIT send 01_0xAA -> o_data_a=0xAA next cycle, o_tx_data stays 0x64; next op 11_0x22 (SUB) -> o_tx_data=0x9B.
- Overrun: send 11_0x24 while o_busy=1 -> o_overrun 1-cycle pulse, o_op unchanged, no extra o_tx_start; after i_tx_done a fresh 11_0x24 (AND) -> o_tx_data = A&B.
- Reserved/ignored: frame 00_0xFF and a stray i_tx_done in S_IDLE -> no output or state change.
- Reset mid-op: i_reset in cycle N+1 after an operator frame -> no o_tx_start, all outputs 0, state S_IDLE; a following full sequence works normally.
